// File: rtl/open_riscv_soc_pkg.sv
// Shared constants and ALU helpers for the minimal RV32I SoC.
package open_riscv_pkg;

    localparam int ROM_DEPTH = 4096;
    localparam int ROM_AW    = $clog2(ROM_DEPTH);

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Unlisted funct7 patterns are illegal and must retire as NOPs.
    function automatic logic alu_legal(
        input logic       is_imm,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        logic ok;
        ok = 1'b1;
        if (is_imm) begin
            if (f3 == F3_SLL)
                ok = (f7 == F7_BASE);
            else if (f3 == F3_SR)
                ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        end else begin
            ok = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        end
        return ok;
    endfunction

    function automatic logic [31:0] alu_calc(
        input logic [2:0]  f3,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] y;
        case (f3)
            F3_ADD:  y = alt ? (a - b) : (a + b);
            F3_SLL:  y = a << b[4:0];
            F3_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: y = {31'b0, a < b};
            F3_XOR:  y = a ^ b;
            F3_SR:   y = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   y = a | b;
            default: y = a & b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/open_riscv_soc_if.sv
// Instruction fetch bus between the core and the ROM.
interface open_riscv_soc_if;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output addr, input rdata);
    modport slave  (input addr, output rdata);
endinterface

// File: rtl/open_riscv_soc_core.sv
// Two-stage RV32I core (fetch, execute) and its register file.
module open_riscv_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : regs[i_raddr2];

endmodule

module open_risc_v
    import open_riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    open_riscv_soc_if.master bus
);

    logic [31:0] r_pc;
    logic [31:0] r_ex_pc;
    logic        r_valid;

    logic [31:0] w_inst;
    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_rs1v;
    logic [31:0] w_rs2v;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_we;
    logic [31:0] w_wdata;
    logic        w_jump;
    logic [31:0] w_tgt;
    logic        w_taken;

    // A cleared valid flag turns the ROM word into a bubble.
    assign w_inst = r_valid ? bus.rdata : NOP_INST;
    assign w_opc  = w_inst[6:0];
    assign w_rd   = w_inst[11:7];
    assign w_f3   = w_inst[14:12];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_f7   = w_inst[31:25];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                      w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                      w_inst[20], w_inst[30:21], 1'b0};

    open_riscv_regs regs_inst (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_wdata),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1v),
        .o_rdata2 (w_rs2v)
    );

    always_comb begin
        w_we    = 1'b0;
        w_wdata = '0;
        w_jump  = 1'b0;
        w_tgt   = r_ex_pc + w_imm_b;
        w_taken = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_we    = 1'b1;
                w_wdata = w_imm_u;
            end
            OPC_AUIPC: begin
                w_we    = 1'b1;
                w_wdata = r_ex_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_we    = 1'b1;
                w_wdata = r_ex_pc + 32'd4;
                w_jump  = 1'b1;
                w_tgt   = r_ex_pc + w_imm_j;
            end
            OPC_JALR: begin
                if (w_f3 == F3_JALR) begin
                    w_we    = 1'b1;
                    w_wdata = r_ex_pc + 32'd4;
                    w_jump  = 1'b1;
                    w_tgt   = (w_rs1v + w_imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  w_taken = (w_rs1v == w_rs2v);
                    F3_BNE:  w_taken = (w_rs1v != w_rs2v);
                    F3_BLT:  w_taken = ($signed(w_rs1v) < $signed(w_rs2v));
                    F3_BGE:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
                    F3_BLTU: w_taken = (w_rs1v < w_rs2v);
                    F3_BGEU: w_taken = (w_rs1v >= w_rs2v);
                    default: w_taken = 1'b0;
                endcase
                w_jump = w_taken;
            end
            OPC_OP_IMM: begin
                if (alu_legal(1'b1, w_f3, w_f7)) begin
                    w_we    = 1'b1;
                    w_wdata = alu_calc(w_f3, (w_f3 == F3_SR) && w_f7[5],
                                       w_rs1v, w_imm_i);
                end
            end
            OPC_OP: begin
                if (alu_legal(1'b0, w_f3, w_f7)) begin
                    w_we    = 1'b1;
                    w_wdata = alu_calc(w_f3, w_f7[5], w_rs1v, w_rs2v);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_ex_pc <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_jump ? w_tgt : (r_pc + 32'd4);
            r_ex_pc <= r_pc;
            r_valid <= ~w_jump;
        end
    end

    assign bus.addr = r_pc;

endmodule

// File: rtl/open_riscv_soc_ram.sv
// Reusable dual-port RAM, one write port and one registered read port.
module dual_ram_template #(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] memory [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            memory[i_waddr] <= i_wdata;
        r_rdata <= memory[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/open_riscv_soc.sv
// SoC top: RV32I core fetching from a synchronous-read instruction ROM.
module rom
    import open_riscv_pkg::*;
(
    input  logic            clk,
    open_riscv_soc_if.slave bus
);

    // Byte offset and out-of-range bits are dropped: fetch wraps in ROM.
    logic w_unused;
    assign w_unused = ^{bus.addr[31:ROM_AW+2], bus.addr[1:0]};

    if (1'b1) begin : rom_32bit
        dual_ram_template #(
            .DW    (32),
            .DEPTH (ROM_DEPTH)
        ) dual_ram_template_isnt (
            .clk     (clk),
            .i_we    (1'b0),
            .i_waddr ('0),
            .i_wdata ('0),
            .i_raddr (bus.addr[ROM_AW+1:2]),
            .o_rdata (bus.rdata)
        );
    end

endmodule

module open_riscv_soc (
    input logic clk,
    input logic rst
);

    open_riscv_soc_if bus ();

    open_risc_v open_risc_v_inst (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rom rom_inst (
        .clk (clk),
        .bus (bus)
    );

endmodule

// File: tb/tb_open_riscv_soc.sv
// Directed program bench for open_riscv_soc with a register scoreboard.
module tb_open_riscv_soc;

    localparam logic [6:0] OPI   = 7'h13;
    localparam logic [6:0] OPR   = 7'h33;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] JALR  = 7'h67;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [31:0] prog [40];
    logic [31:0] exp_regs [32];

    open_riscv_soc dut (
        .clk (clk),
        .rst (rst)
    );

    open_riscv_soc_if mon ();
    assign mon.addr  = dut.bus.addr;
    assign mon.rdata = dut.bus.rdata;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] ei(logic [11:0] imm, logic [4:0] rs1,
                                       logic [2:0] f3, logic [4:0] rd,
                                       logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] er(logic [6:0] f7, logic [4:0] rs2,
                                       logic [4:0] rs1, logic [2:0] f3,
                                       logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] eu(logic [19:0] imm, logic [4:0] rd,
                                       logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] eb(logic [12:0] o, logic [4:0] rs2,
                                       logic [4:0] rs1, logic [2:0] f3);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] ej(logic [20:0] o, logic [4:0] rd);
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] rx(int i);
        return dut.open_risc_v_inst.regs_inst.regs[i];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.idx = i;
            e.val = exp_regs[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d entries left, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: the program signals completion through x26.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && rx(26) === 32'd1) begin
                #200;
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("x%0d", e.idx), rx(e.idx), e.val);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;

        prog[0]  = ei(12'd5,   5'd0,  3'd0, 5'd1,  OPI);
        prog[1]  = ei(12'hFFD, 5'd0,  3'd0, 5'd2,  OPI);
        prog[2]  = er(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        prog[3]  = er(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
        prog[4]  = er(7'h00, 5'd2, 5'd1, 3'd3, 5'd5);
        prog[5]  = eu(20'h80000, 5'd6, LUI);
        prog[6]  = ei(12'h404, 5'd6,  3'd5, 5'd7,  OPI);
        prog[7]  = ei(12'h004, 5'd6,  3'd5, 5'd8,  OPI);
        prog[8]  = ej(21'd8, 5'd1);
        prog[9]  = ei(12'd1,   5'd0,  3'd0, 5'd9,  OPI);
        prog[10] = ei(12'd7,   5'd0,  3'd0, 5'd0,  OPI);
        prog[11] = eb(13'd8, 5'd0, 5'd0, 3'd0);
        prog[12] = ei(12'd1,   5'd0,  3'd0, 5'd10, OPI);
        prog[13] = ei(12'h041, 5'd0,  3'd0, 5'd11, OPI);
        prog[14] = ei(12'd0,   5'd11, 3'd0, 5'd12, JALR);
        prog[15] = ei(12'd1,   5'd0,  3'd0, 5'd13, OPI);
        prog[16] = eb(13'd8, 5'd2, 5'd1, 3'd1);
        prog[17] = ei(12'd1,   5'd0,  3'd0, 5'd14, OPI);
        prog[18] = eb(13'd8, 5'd1, 5'd2, 3'd4);
        prog[19] = ei(12'd1,   5'd0,  3'd0, 5'd15, OPI);
        prog[20] = eb(13'd8, 5'd1, 5'd2, 3'd6);
        prog[21] = ei(12'h016, 5'd0,  3'd0, 5'd16, OPI);
        prog[22] = eb(13'd8, 5'd1, 5'd2, 3'd5);
        prog[23] = ei(12'h017, 5'd0,  3'd0, 5'd17, OPI);
        prog[24] = eb(13'd8, 5'd1, 5'd2, 3'd7);
        prog[25] = ei(12'd1,   5'd0,  3'd0, 5'd18, OPI);
        prog[26] = ei(12'h00F, 5'd2,  3'd4, 5'd19, OPI);
        prog[27] = ei(12'd0,   5'd2,  3'd2, 5'd20, OPI);
        prog[28] = er(7'h00, 5'd1, 5'd2, 3'd2, 5'd21);
        prog[29] = er(7'h00, 5'd11, 5'd1, 3'd1, 5'd22);
        prog[30] = eu(20'h00001, 5'd23, AUIPC);
        prog[31] = er(7'h20, 5'd1, 5'd4, 3'd5, 5'd24);
        prog[32] = ei(12'h700, 5'd1,  3'd6, 5'd25, OPI);
        prog[33] = ei(12'h0F0, 5'd19, 3'd7, 5'd28, OPI);
        prog[34] = er(7'h00, 5'd11, 5'd6, 3'd5, 5'd29);
        prog[35] = ei(12'h004, 5'd11, 3'd1, 5'd30, OPI);
        prog[36] = ei(12'd0,   5'd0,  3'd2, 5'd31, 7'h03);
        prog[37] = ei(12'd1,   5'd0,  3'd0, 5'd27, OPI);
        prog[38] = ei(12'd1,   5'd0,  3'd0, 5'd26, OPI);
        prog[39] = ej(21'd0, 5'd0);

        exp_regs = '{
            32'h0,        32'h24,       32'hFFFF_FFFD, 32'h2,
            32'hFFFF_FFF8, 32'h1,       32'h8000_0000, 32'hF800_0000,
            32'h0800_0000, 32'h0,       32'h0,         32'h41,
            32'h3C,       32'h0,        32'h0,         32'h0,
            32'h16,       32'h17,       32'h0,         32'hFFFF_FFF2,
            32'h1,        32'h1,        32'h48,        32'h1078,
            32'hFFFF_FFFF, 32'h724,     32'h1,         32'h1,
            32'hF0,       32'h4000_0000, 32'h410,      32'h0
        };

        for (int i = 0; i < 4096; i++)
            dut.rom_inst.rom_32bit.dual_ram_template_isnt.memory[i] <= 32'h0;
        for (int i = 0; i < 40; i++)
            dut.rom_inst.rom_32bit.dual_ram_template_isnt.memory[i] <= prog[i];

        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", mon.addr, 32'h0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("reset x%0d", i), rx(i), 32'h0);

        push_expect();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("x1 before retire", rx(1), 32'h0);
        @(posedge clk);
        #1;
        chk("x1 first retire", rx(1), 32'h5);
        wait_drain("run1");

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("halt reset pc", mon.addr, 32'h0);
        chk("halt reset x26", rx(26), 32'h0);
        chk("halt reset x27", rx(27), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset pc", mon.addr, 32'h0);
        chk("mid reset x1", rx(1), 32'h0);
        chk("mid reset x3", rx(3), 32'h0);

        push_expect();
        @(negedge clk);
        rst = 1'b1;
        wait_drain("run2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
